// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory controller.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Request attributes carried alongside the synchronous RAM read.
    typedef struct packed {
        logic       vld;
        logic       we;
        logic       flt;
        logic       uns;
        logic [1:0] size;
        logic [1:0] lane;
    } meta_t;

    function automatic logic [3:0] be_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: be_mask = 4'b0001 << lane;
            SZ_HALF: be_mask = 4'b0011 << lane;
            default: be_mask = 4'b1111;
        endcase
    endfunction

    // Picks the addressed byte/half out of the RAM word and extends it.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            SZ_BYTE: load_extend = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: load_extend = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_extend = word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the MEM stage and the data-memory controller.
interface dmem_if;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/dmem_bank.sv
// Byte-lane RAM, synchronous read, per-lane write enable; no reset on storage.
module dmem_bank #(
    parameter  int DEPTH_WORDS = 16384,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_re,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];
        logic [7:0] r_q;

        // One byte column: write on its enable, register the read.
        always_ff @(posedge clk) begin
            if (i_be[g]) r_mem[i_idx] <= i_wdata[g*8 +: 8];
            if (i_re)    r_q          <= r_mem[i_idx];
        end

        assign o_rdata[g*8 +: 8] = r_q;
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: address translation, fault check, sub-word
// stores/loads and a LATENCY-cycle valid-tagged response pipeline.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 16384,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    dmem_if.slave   bus
);

    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

    logic [31:0] w_off;
    logic        w_in_range;
    logic [1:0]  w_lane;
    logic        w_fault;
    logic        w_wr;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ram_q;
    logic [31:0] w_rsp_rdata;
    logic        w_rsp_fault;
    meta_t       r_m;

    // Addresses below BASE_ADDR wrap to a huge offset and land out of range.
    assign w_off      = bus.req_addr - BASE_ADDR;
    assign w_in_range = {1'b0, w_off} < LIMIT;
    assign w_lane     = w_off[1:0];

    // Fault on range, alignment for the access size, or the reserved size.
    always_comb begin
        w_fault = !w_in_range;
        case (bus.req_size)
            SZ_BYTE: ;
            SZ_HALF: w_fault = w_fault | w_lane[0];
            SZ_WORD: w_fault = w_fault | (w_lane != 2'd0);
            default: w_fault = 1'b1;
        endcase
    end

    // rst_n gates the write so a store held during reset never commits.
    assign w_wr = bus.req_valid & bus.req_we & ~w_fault & rst_n;
    assign w_be = w_wr ? be_mask(bus.req_size, w_lane) : 4'b0000;

    // Replicate sub-word data across lanes; the byte enables pick the target.
    always_comb begin
        case (bus.req_size)
            SZ_BYTE: w_wdata = {4{bus.req_wdata[7:0]}};
            SZ_HALF: w_wdata = {2{bus.req_wdata[15:0]}};
            default: w_wdata = bus.req_wdata;
        endcase
    end

    dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
        .clk     (clk),
        .i_re    (bus.req_valid & ~bus.req_we),
        .i_be    (w_be),
        .i_idx   (w_off[AW+1:2]),
        .i_wdata (w_wdata),
        .o_rdata (w_ram_q)
    );

    // Carry the request attributes in step with the RAM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m <= '0;
        end else begin
            r_m.vld  <= bus.req_valid;
            r_m.we   <= bus.req_we;
            r_m.flt  <= w_fault;
            r_m.uns  <= bus.req_unsigned;
            r_m.size <= bus.req_size;
            r_m.lane <= w_lane;
        end
    end

    assign w_rsp_rdata = (r_m.vld & ~r_m.we & ~r_m.flt)
                       ? load_extend(w_ram_q, r_m.lane, r_m.size, r_m.uns) : 32'd0;
    assign w_rsp_fault = r_m.vld & r_m.flt;

    if (LATENCY == 2) begin : g_lat2
        logic        r_vld;
        logic [31:0] r_rdata;
        logic        r_fault;

        // Extra output register after extension for timing headroom.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld   <= 1'b0;
                r_rdata <= 32'd0;
                r_fault <= 1'b0;
            end else begin
                r_vld   <= r_m.vld;
                r_rdata <= w_rsp_rdata;
                r_fault <= w_rsp_fault;
            end
        end

        assign bus.rsp_valid = r_vld;
        assign bus.rsp_rdata = r_rdata;
        assign bus.rsp_fault = r_fault;
    end else begin : g_lat1
        assign bus.rsp_valid = r_m.vld;
        assign bus.rsp_rdata = w_rsp_rdata;
        assign bus.rsp_fault = w_rsp_fault;
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: three configurations driven in lockstep against a
// byte-addressed reference memory with a per-instance response queue.
module tb_dmem_ctrl;

    typedef struct {
        logic        vld;
        logic        flt;
        logic        chk;
        logic [31:0] rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        t_vld  [3];
    logic        t_we   [3];
    logic [1:0]  t_sz   [3];
    logic        t_uns  [3];
    logic [31:0] t_addr [3];
    logic [31:0] t_wd   [3];
    logic [2:0]  o_vld;
    logic [2:0]  o_flt;
    logic [31:0] o_rd   [3];

    logic [31:0] last_rd [3];
    logic        last_f  [3];
    logic [7:0]  mem [longint];
    exp_t        q [3][$];
    int          n_chk = 0;
    int          n_err = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_if bus ();
        assign bus.req_valid    = t_vld[g];
        assign bus.req_we       = t_we[g];
        assign bus.req_size     = t_sz[g];
        assign bus.req_unsigned = t_uns[g];
        assign bus.req_addr     = t_addr[g];
        assign bus.req_wdata    = t_wd[g];
        assign o_vld[g]         = bus.rsp_valid;
        assign o_flt[g]         = bus.rsp_fault;
        assign o_rd[g]          = bus.rsp_rdata;

        dmem_ctrl #(
            .DEPTH_WORDS (g == 1 ? 16 : 16384),
            .BASE_ADDR   (g == 1 ? 32'h0000_4000 : 32'h0),
            .LATENCY     (g == 2 ? 2 : 1)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    function automatic logic [31:0] base_of(int d);
        return (d == 1) ? 32'h4000 : 32'h0;
    endfunction
    function automatic longint depth_of(int d);
        return (d == 1) ? 16 : 16384;
    endfunction
    function automatic int lat_of(int d);
        return (d == 2) ? 2 : 1;
    endfunction
    function automatic longint key(int d, logic [31:0] a);
        return (longint'(d) << 40) | longint'({32'd0, a});
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(int d, logic we, logic [1:0] sz, logic uns, logic [31:0] a, logic [31:0] wd);
        t_vld[d] = 1'b1; t_we[d] = we; t_sz[d] = sz; t_uns[d] = uns; t_addr[d] = a; t_wd[d] = wd;
    endtask

    task automatic clr_req();
        for (int d = 0; d < 3; d++) begin
            t_vld[d] = 1'b0; t_we[d] = 1'b0; t_sz[d] = 2'd0; t_uns[d] = 1'b0;
            t_addr[d] = 32'd0; t_wd[d] = 32'd0;
        end
    endtask

    task automatic init_q();
        exp_t idle;
        idle = '{vld: 1'b0, flt: 1'b0, chk: 1'b0, rd: 32'd0};
        for (int d = 0; d < 3; d++) begin
            q[d].delete();
            if (lat_of(d) == 2) q[d].push_back(idle);
        end
    endtask

    // Reference: a byte array updated by the request rules, no lanes or masks.
    task automatic model(int d, output exp_t e);
        logic [31:0] off;
        longint      nb, v;
        off = t_addr[d] - base_of(d);
        nb  = longint'(1) << t_sz[d];
        e   = '{vld: t_vld[d], flt: 1'b0, chk: 1'b1, rd: 32'd0};
        if (t_vld[d]) begin
            e.flt = (t_sz[d] == 2'd3) || (longint'({32'd0, off}) >= depth_of(d) * 4)
                    || ((longint'({32'd0, off}) % nb) != 0);
            if (!e.flt && t_we[d]) begin
                for (int i = 0; i < nb; i++) mem[key(d, off + i)] = t_wd[d][8*i +: 8];
            end else if (!e.flt) begin
                v = 0;
                for (int i = 0; i < nb; i++) begin
                    if (!mem.exists(key(d, off + i))) e.chk = 1'b0;
                    else v = v | (longint'(mem[key(d, off + i)]) << (8 * i));
                end
                if (!t_uns[d] && nb < 4 && v[8*nb-1]) v = v - (longint'(1) << (8 * nb));
                e.rd = v[31:0];
            end
        end
    endtask

    // One clock: queue the expected responses, step to the next negedge, compare.
    task automatic cycle();
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            model(d, e);
            q[d].push_back(e);
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            e = q[d].pop_front();
            last_rd[d] = o_rd[d];
            last_f[d]  = o_flt[d];
            check($sformatf("d%0d_vld", d), {31'd0, o_vld[d]}, {31'd0, e.vld});
            if (e.vld) begin
                check($sformatf("d%0d_flt", d), {31'd0, o_flt[d]}, {31'd0, e.flt});
                if (e.chk) check($sformatf("d%0d_rd", d), o_rd[d], e.rd);
            end
        end
        clr_req();
    endtask

    task automatic ck_last(int d, string tag, logic [31:0] rd, logic f);
        check({tag, "_rd"}, last_rd[d], rd);
        check({tag, "_f"}, {31'd0, last_f[d]}, {31'd0, f});
    endtask

    task automatic ck_zero(string tag);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s_vld%0d", tag, d), {31'd0, o_vld[d]}, 32'd0);
            check($sformatf("%s_rd%0d", tag, d), o_rd[d], 32'd0);
            check($sformatf("%s_f%0d", tag, d), {31'd0, o_flt[d]}, 32'd0);
        end
    endtask

    task automatic rand_req(int d);
        logic [31:0] off;
        logic [1:0]  sz;
        int          s;
        if ($urandom_range(0, 3) == 0) return;
        s  = $urandom_range(0, 15);
        sz = (s < 4) ? 2'd0 : (s < 8) ? 2'd1 : (s < 15) ? 2'd2 : 2'd3;
        off = $urandom_range(0, 67);
        if (sz != 2'd3 && $urandom_range(0, 3) != 0) off = off & ~((32'd1 << sz) - 1);
        if ($urandom_range(0, 19) == 0) off = -(32'd4 * $urandom_range(1, 4));
        set_req(d, $urandom_range(0, 9) < 4, sz, 1'($urandom_range(0, 1)), base_of(d) + off, $urandom);
    endtask

    initial begin
        clr_req();
        #1;
        ck_zero("rst");
        @(negedge clk);
        ck_zero("rst_hold");
        rst_n = 1'b1;
        init_q();

        // Scenarios 1-3 on the LATENCY=1 and LATENCY=2 instances in parallel.
        set_req(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF); set_req(2, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF); cycle();
        set_req(0, 0, 2'd2, 0, 32'h10, 0); set_req(2, 0, 2'd2, 0, 32'h10, 0); cycle();
        ck_last(0, "lw", 32'hDEADBEEF, 0);
        set_req(0, 0, 2'd0, 0, 32'h13, 0); set_req(2, 0, 2'd0, 0, 32'h13, 0); cycle();
        ck_last(0, "lb", 32'hFFFFFFDE, 0);
        ck_last(2, "lw_lat2", 32'hDEADBEEF, 0);
        set_req(0, 0, 2'd0, 1, 32'h13, 0); cycle(); ck_last(0, "lbu", 32'h000000DE, 0);
        set_req(0, 0, 2'd1, 0, 32'h10, 0); cycle(); ck_last(0, "lh", 32'hFFFFBEEF, 0);
        set_req(0, 0, 2'd1, 1, 32'h12, 0); cycle(); ck_last(0, "lhu", 32'h0000DEAD, 0);
        set_req(0, 1, 2'd1, 0, 32'h12, 32'hAAAA1234); set_req(2, 1, 2'd1, 0, 32'h12, 32'hAAAA1234); cycle();
        set_req(0, 1, 2'd0, 0, 32'h10, 32'hAAAAAA55); set_req(2, 1, 2'd0, 0, 32'h10, 32'hAAAAAA55); cycle();
        set_req(0, 0, 2'd2, 0, 32'h10, 0); set_req(2, 0, 2'd2, 0, 32'h10, 0); cycle();
        ck_last(0, "sub_wr", 32'h1234BE55, 0);
        cycle();
        ck_last(2, "sub_wr_lat2", 32'h1234BE55, 0);

        // Scenario 4: misaligned and illegal-size requests.
        set_req(0, 1, 2'd2, 0, 32'h11, 32'h0); cycle(); ck_last(0, "sw_mis", 32'h0, 1);
        set_req(0, 0, 2'd1, 0, 32'h13, 0);     cycle(); ck_last(0, "lh_mis", 32'h0, 1);
        set_req(0, 0, 2'd2, 0, 32'h10, 0);     cycle(); ck_last(0, "unchanged", 32'h1234BE55, 0);
        set_req(0, 0, 2'd3, 0, 32'h10, 0);     cycle(); ck_last(0, "size3", 32'h0, 1);

        // Scenario 5: based, 16-word instance edges.
        set_req(1, 0, 2'd2, 0, 32'h3FFC, 0);          cycle(); ck_last(1, "below_base", 32'h0, 1);
        set_req(1, 0, 2'd2, 0, 32'h4040, 0);          cycle(); ck_last(1, "past_end", 32'h0, 1);
        set_req(1, 1, 2'd2, 0, 32'h403C, 32'hCAFEF00D); cycle();
        set_req(1, 0, 2'd2, 0, 32'h403C, 0);          cycle(); ck_last(1, "top_word", 32'hCAFEF00D, 0);

        // Fill a 64-byte window everywhere so random loads hit known data.
        for (int w = 0; w < 16; w++) begin
            for (int d = 0; d < 3; d++) set_req(d, 1, 2'd2, 0, base_of(d) + 32'(4 * w), $urandom);
            cycle();
        end

        repeat (300) begin
            for (int d = 0; d < 3; d++) rand_req(d);
            cycle();
        end

        // Reset mid-stream: loads in flight, a store presented during reset.
        for (int d = 0; d < 3; d++) set_req(d, 0, 2'd2, 0, base_of(d) + 32'h20, 0);
        cycle();
        for (int d = 0; d < 3; d++) set_req(d, 1, 2'd2, 0, base_of(d) + 32'h20, 32'h5A5A_0F0F);
        rst_n = 1'b0;
        #1;
        ck_zero("rst_async");
        @(negedge clk);
        ck_zero("rst_mid");
        rst_n = 1'b1;
        clr_req();
        init_q();
        for (int d = 0; d < 3; d++) set_req(d, 0, 2'd2, 0, base_of(d) + 32'h20, 0);
        cycle();
        cycle();

        repeat (100) begin
            for (int d = 0; d < 3; d++) rand_req(d);
            cycle();
        end
        repeat (2) cycle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
